// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (DM), DM first, one access in flight.
// Build with MEM_ARB_PERF_CNT_EN defined to add perf_*_cnt transaction/stall/timeout counters.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_rvalid,
    output logic [DW-1:0]     if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [AW-1:0]     dm_addr,
    input  logic [DW-1:0]     dm_wdata,
    input  logic [DW/8-1:0]   dm_be,
    output logic              dm_rvalid,
    output logic [DW-1:0]     dm_rdata,
    output logic              err,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_be,
    input  logic              mem_rvalid,
    input  logic [DW-1:0]     mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_cnt,
    output logic [31:0]       perf_dm_cnt,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_err_cnt
`endif
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_DM, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          expired;

    assign expired = (cnt_q == CW'(TIMEOUT));
    assign stall   = (if_req & ~if_rvalid) | (dm_req & ~dm_rvalid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rvalid <= 1'b0;
            dm_rdata  <= '0;
            err       <= 1'b0;
        end else begin
            mem_req   <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            err       <= 1'b0;
            case (state_q)
                IDLE: begin
                    // mem_rvalid here is a stray or post-timeout response and is dropped
                    if (dm_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_be    <= dm_we ? dm_be : '1;
                        state_q   <= WAIT_DM;
                    end else if (if_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                        state_q   <= WAIT_IF;
                    end
                end
                WAIT_IF, WAIT_DM: begin
                    if (mem_rvalid || expired) begin
                        if (state_q == WAIT_IF) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rvalid ? mem_rdata : '0;
                        end else begin
                            dm_rvalid <= 1'b1;
                            dm_rdata  <= mem_rvalid ? mem_rdata : '0;
                        end
                        err     <= ~mem_rvalid;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else if (!expired) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_cnt    <= '0;
            perf_dm_cnt    <= '0;
            perf_stall_cnt <= '0;
            perf_err_cnt   <= '0;
        end else begin
            if (if_rvalid) perf_if_cnt    <= perf_if_cnt + 32'd1;
            if (dm_rvalid) perf_dm_cnt    <= perf_dm_cnt + 32'd1;
            if (stall)     perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (err)       perf_err_cnt   <= perf_err_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a word-addressed reference memory.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [31:0]   dm_addr = '0;
    logic [31:0]   dm_wdata = '0;
    logic [3:0]    dm_be = '0;
    logic          dm_rvalid;
    logic [31:0]   dm_rdata;
    logic          err;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_rvalid = 1'b0;
    logic [31:0]   mem_rdata = '0;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0]   perf_if_cnt, perf_dm_cnt, perf_stall_cnt, perf_err_cnt;
`endif

    int nchk = 0;
    int nfail = 0;
    int lat_cfg = 1;
    bit spur = 1'b0;
    int exp_if = 0, exp_dm = 0, exp_err = 0;
    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .err(err), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
        , .perf_if_cnt(perf_if_cnt), .perf_dm_cnt(perf_dm_cnt),
        .perf_stall_cnt(perf_stall_cnt), .perf_err_cnt(perf_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory device: answers each command after lat_cfg cycles, or emits one stray strobe on request.
    initial begin : device
        logic [31:0] ra, rd;
        int rl;
        forever begin
            tick();
            if (spur) begin
                spur = 1'b0;
                mem_rvalid = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
                tick();
                mem_rvalid = 1'b0;
            end else if (mem_req) begin
                ra = mem_addr;
                rl = lat_cfg;
                if (mem_we) begin
                    dev_mem[ra] = merge(dev_mem.exists(ra) ? dev_mem[ra] : init_val(ra), mem_wdata, mem_be);
                    rd = $urandom;
                end else begin
                    rd = dev_mem.exists(ra) ? dev_mem[ra] : init_val(ra);
                end
                repeat (rl) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata = rd;
                tick();
                mem_rvalid = 1'b0;
            end
        end
    end

    task automatic access(input bit dm, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input int lat);
        int n;
        bit rv, to, st;
        to = (lat > TO);
        st = dm & we;
        lat_cfg = lat;
        if (dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd; dm_be = be;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        tick();
        chk("grant", mem_req, 1);
        chk("cmd", {mem_we, mem_addr, mem_be}, {st, addr, st ? be : 4'hF});
        if (st) chk("wdata", mem_wdata, wd);
        if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom);
        n = 0;
        rv = 1'b0;
        while (!rv && n < TO + 4) begin
            chk("stall_wait", stall, 1);
            tick();
            n++;
            chk("no_req_in_wait", mem_req, 0);
            rv = dm ? dm_rvalid : if_rvalid;
        end
        chk("latency", n, to ? TO + 1 : lat + 1);
        chk("other_rv", dm ? if_rvalid : dm_rvalid, 0);
        chk("err", err, to);
        if (to) chk("to_rdata", dm ? dm_rdata : if_rdata, 0);
        else if (!st) chk("rdata", dm ? dm_rdata : if_rdata, ref_rd(addr));
        if (st && !to) ref_mem[addr] = merge(ref_rd(addr), wd, be);
        if (dm) exp_dm++; else exp_if++;
        if (to) exp_err++;
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        chk("one_pulse", {if_rvalid, dm_rvalid, err}, 0);
        if (to) begin
            repeat (lat - TO + 2) begin
                tick();
                chk("late_drop", {if_rvalid, dm_rvalid, mem_req}, 0);
            end
        end
    endtask

    initial begin : main
        int n;
        ref_mem[32'h10]  = 32'h0050_0093; dev_mem[32'h10]  = 32'h0050_0093;
        ref_mem[32'h200] = 32'h1234_5678; dev_mem[32'h200] = 32'h1234_5678;
        #2 rst = 1'b0;
        #2;
        chk("reset_outs", {mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rvalid, dm_rvalid, err}, 0);
        chk("reset_rdata", {if_rdata, dm_rdata}, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("idle_no_req", mem_req, 0);

        access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1);
        access(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 5);

        // Simultaneous store and fetch: store first, fetch granted two cycles after dm_rvalid.
        lat_cfg = 2;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF;
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        chk("cont_cmd", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 32'h100});
        n = 0;
        while (!dm_rvalid && n < 20) begin chk("cont_stall", stall, 1); tick(); n++; end
        chk("cont_dm_lat", n, 3);
        chk("cont_if_rv", if_rvalid, 0);
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        exp_dm++;
        dm_req = 1'b0;
        chk("cont_stall_if", stall, 1);
        tick();
        chk("cont_done", {mem_req, stall}, {1'b0, 1'b1});
        tick();
        chk("cont_if_cmd", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h10});
        n = 0;
        while (!if_rvalid && n < 20) begin chk("cont_stall2", stall, 1); tick(); n++; end
        chk("cont_if_lat", n, 3);
        chk("cont_if_data", if_rdata, 32'h0050_0093);
        exp_if++;
        if_req = 1'b0;
        tick();
        access(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1);

        // Fetch that times out; its late response must vanish.
        access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 12);

        spur = 1'b1;
        repeat (4) begin
            tick();
            chk("stray_rv", {if_rvalid, dm_rvalid, err, mem_req}, 0);
        end

        for (int i = 0; i < 24; i++) begin
            bit d, w;
            d = 1'($urandom);
            w = 1'($urandom);
            access(d, w, 32'($urandom_range(0, 15)) << 2, $urandom, 4'($urandom_range(1, 15)),
                   $urandom_range(1, 5));
        end

`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_if", perf_if_cnt, exp_if);
        chk("perf_dm", perf_dm_cnt, exp_dm);
        chk("perf_err", perf_err_cnt, exp_err);
`endif

        // Reset two cycles into a load wait.
        lat_cfg = 6;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        tick();
        chk("rst_grant", mem_req, 1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_outs", {mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rvalid, dm_rvalid, err}, 0);
        chk("rst_mid_rdata", {if_rdata, dm_rdata}, 0);
        dm_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (8) begin
            tick();
            chk("rst_drop", {mem_req, if_rvalid, dm_rvalid, err}, 0);
        end
`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_rst", {perf_if_cnt, perf_err_cnt}, 0);
`endif
        access(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", nchk, nfail);
        $fatal(1);
    end

endmodule
